fft32_bfly_sched: RTL

FFT32_BFLY_SCHED -- requirements
Module: fft32_bfly_sched

---
 rtl/fft32_bfly_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fft32_bfly_sched.sv
// In-place radix-2 DIF butterfly scheduler for a 32-point FFT: 5 stages x 16 butterflies, PIPE_LAT drain gap per stage.
// Writes trail reads by exactly PIPE_LAT cycles; no backpressure, start is honoured only in IDLE.
module fft32_bfly_sched #(
   parameter int PIPE_LAT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       inv,
   output logic       busy,
   output logic       done,
   output logic [2:0] stage,
   output logic       rd_en,
   output logic [4:0] rd_addr0,
   output logic [4:0] rd_addr1,
   output logic [3:0] tw_addr,
   output logic       tw_conj,
   output logic       wr_en,
   output logic [4:0] wr_addr0,
   output logic [4:0] wr_addr1
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t     state_q, state_d;
   logic [4:0] k_q, k_d;
   logic [2:0] stage_q, stage_d;
   logic [2:0] drain_q, drain_d;
   logic       tw_conj_q, tw_conj_d;

   logic [4:0] span;
   logic [4:0] pos;
   logic [4:0] grp;
   logic [4:0] base;

   logic [PIPE_LAT-1:0] wen_q;
   logic [4:0]          wa0_q [PIPE_LAT];
   logic [4:0]          wa1_q [PIPE_LAT];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         k_q       <= '0;
         stage_q   <= '0;
         drain_q   <= '0;
         tw_conj_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         stage_q   <= stage_d;
         drain_q   <= drain_d;
         tw_conj_q <= tw_conj_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      stage_d   = stage_q;
      drain_d   = drain_q;
      tw_conj_d = tw_conj_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               k_d       = '0;
               stage_d   = '0;
               drain_d   = '0;
               tw_conj_d = inv;
            end
         end
         RUN: begin
            if (k_q == 5'd15) begin
               state_d = DRAIN;
               k_d     = '0;
               drain_d = '0;
            end else begin
               k_d = k_q + 5'd1;
            end
         end
         DRAIN: begin
            // Hold off the next stage until every write of this stage has retired.
            if (drain_q == 3'(PIPE_LAT - 1)) begin
               drain_d = '0;
               if (stage_q == 3'd4) begin
                  state_d = DONE;
                  stage_d = '0;
               end else begin
                  state_d = RUN;
                  stage_d = stage_q + 3'd1;
               end
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy    = (state_q == RUN) || (state_q == DRAIN);
   assign done    = (state_q == DONE);
   assign rd_en   = (state_q == RUN);
   assign stage   = stage_q;
   assign tw_conj = tw_conj_q;

   // Butterfly k of stage s pairs addresses that differ only in bit (4-s).
   always_comb begin
      span     = 5'd16 >> stage_q;
      pos      = k_q & (span - 5'd1);
      grp      = k_q >> (3'd4 - stage_q);
      base     = grp << (3'd5 - stage_q);
      rd_addr0 = '0;
      rd_addr1 = '0;
      tw_addr  = '0;
      if (rd_en) begin
         rd_addr0 = base + pos;
         rd_addr1 = base + pos + span;
         tw_addr  = 4'(pos << stage_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wen_q <= '0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            wa0_q[i] <= '0;
            wa1_q[i] <= '0;
         end
      end else begin
         wen_q[0] <= rd_en;
         wa0_q[0] <= rd_addr0;
         wa1_q[0] <= rd_addr1;
         for (int i = 1; i < PIPE_LAT; i++) begin
            wen_q[i] <= wen_q[i-1];
            wa0_q[i] <= wa0_q[i-1];
            wa1_q[i] <= wa1_q[i-1];
         end
      end
   end

   // Read addresses are already zero when idle, so the delayed copies are too.
   assign wr_en    = wen_q[PIPE_LAT-1];
   assign wr_addr0 = wa0_q[PIPE_LAT-1];
   assign wr_addr1 = wa1_q[PIPE_LAT-1];

endmodule
